ir_beacon_classifier: RTL and testbench
=======================================

Name: ir_beacon_classifier

Overview:
- Downstream consumer of the IR edge-count stage.
- Takes one edge count per 1 s measurement window, at 50 MHz clk, and classifies it as beacon A (~1 kHz, 2000 edges/window), beacon B (~10 kHz, 20000 edges/window) or none.
- Requires CONFIRM_N consecutive agreeing windows before reporting a beacon, and DROP_N misses before releasing it.
- Feeds the rover navigation/docking logic with a stable beacon ID plus a change pulse.

Parameters:
- A_LO, 1800, minimum edge count classified as beacon A (inclusive).
- A_HI, 2200, maximum edge count classified as beacon A (inclusive).
- B_LO, 18000, minimum edge count classified as beacon B (inclusive).
- B_HI, 22000, maximum edge count classified as beacon B (inclusive).
- CONFIRM_N, 3, consecutive matching windows needed to lock; legal range 1..255.
- DROP_N, 2, consecutive non-matching windows needed to unlock; legal range 1..255.
- STALE_CYCLES, 75_000_000, clk cycles without count_valid before forced unlock.
- HYST, 100, band widening applied while locked; used only with IR_HYST_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high; clears all state
- edge_count  in  32  edges counted in the last window; sampled only when count_valid=1
- count_valid  in  1  single-cycle pulse marking a new edge_count
- beacon_id  out  2  0=none, 1=A, 2=B; 3 never driven
- beacon_valid  out  1  1 while LOCKED
- beacon_changed  out  1  1-cycle pulse whenever beacon_id changes value
- stale  out  1  1-cycle pulse when the stale timeout fires
- last_count  out  32  edge_count captured at the most recent count_valid

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in SEARCH.
  - cand=0, agree=0, miss=0, stale timer=0.
- Latency: every output is registered and updates on the clk edge that samples count_valid=1. There is no combinational input-to-output path.
- Classification (combinational on edge_count):
  - cls=1 if A_LO<=edge_count<=A_HI.
  - Otherwise cls=2 if B_LO<=edge_count<=B_HI.
  - Otherwise cls=0.
  - Overlapping bands resolve to A.
  - Comparisons are unsigned, 32-bit.
- last_count loads edge_count on every count_valid, in any state.
- SEARCH (beacon_id=0, beacon_valid=0), on count_valid:
  - cls!=0: cand=cls, agree=1. If CONFIRM_N==1, go to LOCKED with beacon_id=cls and pulse beacon_changed. Otherwise go to CONFIRM.
  - cls==0: stay in SEARCH.
- CONFIRM, on count_valid:
  - cls==cand: agree+1. When agree+1==CONFIRM_N, go to LOCKED with beacon_id=cand, beacon_valid=1, beacon_changed pulse.
  - cls!=cand and cls!=0: cand=cls, agree=1, stay in CONFIRM.
  - cls==0: go to SEARCH, agree=0.
- LOCKED, on count_valid:
  - cls==beacon_id: miss=0.
  - Otherwise: miss+1. When miss+1==DROP_N, go to SEARCH with beacon_id=0, beacon_valid=0, beacon_changed pulse, miss=0.
  - A different valid class does not lock directly; it restarts from SEARCH on a later window.
- Stale timer:
  - Counts clk cycles and clears on each count_valid.
  - Saturates; it does not wrap.
  - When it reaches STALE_CYCLES in any state: stale pulses, FSM goes to SEARCH, cand/agree/miss clear.
  - If beacon_id was nonzero: beacon_id=0, beacon_valid=0, beacon_changed pulses.
  - After firing, stale does not pulse again until a count_valid has occurred.
- Simultaneous count_valid and stale expiry: count_valid wins, the timer clears and stale does not fire.
- agree and miss are 8-bit counters and never exceed their thresholds.
- Reset asserted mid-operation returns everything to the reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: IR_HYST_EN.
- Defined: while LOCKED, the band of the locked beacon is widened to [LO-HYST, HI+HYST].
  - The subtraction saturates at 0.
  - The widened band is used only for the cls==beacon_id comparison.
  - SEARCH and CONFIRM use the unwidened bands.
- Undefined: HYST is unused and all states use the nominal bands.

Test Plan:
- Reset, then 3 count_valid pulses with edge_count=2000 -> beacon_id=1, beacon_valid=1 and one beacon_changed pulse, all on the edge sampling the 3rd pulse; last_count=2000.
- Lock on B (3x 20000), then 2x 500 -> beacon_id=0 and beacon_changed pulse on the 2nd miss. Also check that 1x 500 followed by 20000 keeps the lock (miss reset).
- CONFIRM sequence 2000, 20000, 20000, 20000 -> lock on B at the 4th pulse. Sequence 2000, 2000, 0 -> SEARCH, no lock.
- Locked on A, then no count_valid for 75_000_000 cycles -> stale pulse, beacon_id=0, beacon_changed pulse. A count_valid landing on the expiry cycle -> no stale pulse.
- Locked on A, then edge_count=2250:
  - IR_HYST_EN defined: lock is held.
  - IR_HYST_EN undefined: counts as a miss.
  - Also check that 2250 in SEARCH never starts a CONFIRM.
- Assert reset asynchronously mid-CONFIRM (agree=2) -> all outputs 0 immediately; the next two 2000 windows alone do not lock.

Source files
------------

// File: rtl/ir_beacon_classifier.sv
// IR beacon classifier: turns one edge count per window into a debounced beacon ID (0=none, 1=A, 2=B).
// Optional IR_HYST_EN macro widens the locked beacon's band by HYST while LOCKED.
module ir_beacon_classifier #(
    parameter int unsigned A_LO         = 1800,
    parameter int unsigned A_HI         = 2200,
    parameter int unsigned B_LO         = 18000,
    parameter int unsigned B_HI         = 22000,
    parameter int unsigned CONFIRM_N    = 3,
    parameter int unsigned DROP_N       = 2,
    parameter int unsigned STALE_CYCLES = 75_000_000,
    parameter int unsigned HYST         = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] edge_count,
    input  logic        count_valid,
    output logic [1:0]  beacon_id,
    output logic        beacon_valid,
    output logic        beacon_changed,
    output logic        stale,
    output logic [31:0] last_count
);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    localparam logic [7:0]  CONFIRM_T  = 8'(CONFIRM_N);
    localparam logic [7:0]  DROP_T     = 8'(DROP_N);
    localparam logic [31:0] STALE_T    = 32'(STALE_CYCLES);
    localparam logic [31:0] STALE_LAST = STALE_T - 32'd1;

`ifdef IR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Widened bounds are 33 bits so HI+HYST cannot wrap; LO-HYST saturates at zero.
    localparam logic [32:0] A_LO_W = (A_LO > HYST) ? 33'(A_LO - HYST) : 33'd0;
    localparam logic [32:0] A_HI_W = 33'(A_HI) + 33'(HYST);
    localparam logic [32:0] B_LO_W = (B_LO > HYST) ? 33'(B_LO - HYST) : 33'd0;
    localparam logic [32:0] B_HI_W = 33'(B_HI) + 33'(HYST);

    state_t      state, state_d;
    logic [1:0]  cand, cand_d;
    logic [7:0]  agree, agree_d;
    logic [7:0]  miss, miss_d;
    logic [31:0] timer, timer_d;
    logic [1:0]  id_d;
    logic        changed_d, stale_d;
    logic [1:0]  cls;
    logic        hold;
    logic [32:0] count_x;

    assign count_x      = {1'b0, edge_count};
    assign beacon_valid = (state == LOCKED);

    // Nominal classification; A is tested first so overlapping bands resolve to A.
    always_comb begin
        cls = 2'd0;
        if (edge_count >= A_LO && edge_count <= A_HI)
            cls = 2'd1;
        else if (edge_count >= B_LO && edge_count <= B_HI)
            cls = 2'd2;
    end

    always_comb begin
        hold = (cls == beacon_id);
        if (HYST_ON) begin
            case (beacon_id)
                2'd1:    hold = (count_x >= A_LO_W) && (count_x <= A_HI_W);
                2'd2:    hold = (count_x >= B_LO_W) && (count_x <= B_HI_W);
                default: hold = 1'b0;
            endcase
        end
    end

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        cand_d    = cand;
        agree_d   = agree;
        miss_d    = miss;
        id_d      = beacon_id;
        changed_d = 1'b0;
        stale_d   = 1'b0;
        timer_d   = (timer == STALE_T) ? timer : timer + 32'd1;

        if (count_valid) begin
            timer_d = '0;
            case (state)
                SEARCH: begin
                    if (cls != 2'd0) begin
                        cand_d  = cls;
                        agree_d = 8'd1;
                        if (CONFIRM_T == 8'd1) begin
                            state_d   = LOCKED;
                            id_d      = cls;
                            changed_d = 1'b1;
                            miss_d    = '0;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (cls == cand) begin
                        agree_d = agree + 8'd1;
                        if (agree + 8'd1 == CONFIRM_T) begin
                            state_d   = LOCKED;
                            id_d      = cand;
                            changed_d = 1'b1;
                            miss_d    = '0;
                        end
                    end else if (cls != 2'd0) begin
                        cand_d  = cls;
                        agree_d = 8'd1;
                    end else begin
                        state_d = SEARCH;
                        agree_d = '0;
                    end
                end
                LOCKED: begin
                    if (hold) begin
                        miss_d = '0;
                    end else if (miss + 8'd1 == DROP_T) begin
                        state_d   = SEARCH;
                        id_d      = 2'd0;
                        changed_d = 1'b1;
                        miss_d    = '0;
                        agree_d   = '0;
                        cand_d    = 2'd0;
                    end else begin
                        miss_d = miss + 8'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else if (timer == STALE_LAST) begin
            // Fires only on the cycle the saturating timer reaches the limit, hence once per silence.
            stale_d = 1'b1;
            state_d = SEARCH;
            cand_d  = 2'd0;
            agree_d = '0;
            miss_d  = '0;
            if (beacon_id != 2'd0) begin
                id_d      = 2'd0;
                changed_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= SEARCH;
            cand           <= 2'd0;
            agree          <= '0;
            miss           <= '0;
            timer          <= '0;
            beacon_id      <= 2'd0;
            beacon_changed <= 1'b0;
            stale          <= 1'b0;
            last_count     <= '0;
        end else begin
            state          <= state_d;
            cand           <= cand_d;
            agree          <= agree_d;
            miss           <= miss_d;
            timer          <= timer_d;
            beacon_id      <= id_d;
            beacon_changed <= changed_d;
            stale          <= stale_d;
            if (count_valid)
                last_count <= edge_count;
        end
    end

endmodule

// File: tb/tb_ir_beacon_classifier.sv
// Self-checking bench for ir_beacon_classifier: directed steps plus random windows against a run-length model.
// STALE_CYCLES is shortened so the stale timeout is reachable in simulation.
module tb_ir_beacon_classifier;

    localparam int unsigned S       = 300;
    localparam int unsigned CONFIRM = 3;
    localparam int unsigned DROP    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] edge_count;
    logic        count_valid;
    logic [1:0]  beacon_id;
    logic        beacon_valid;
    logic        beacon_changed;
    logic        stale;
    logic [31:0] last_count;

    ir_beacon_classifier #(.STALE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .edge_count(edge_count), .count_valid(count_valid),
        .beacon_id(beacon_id), .beacon_valid(beacon_valid), .beacon_changed(beacon_changed),
        .stale(stale), .last_count(last_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: locked id, run length of the current candidate class, misses, silence length.
    int          m_id, m_run, m_prev, m_miss, m_since;
    bit          m_chg;
    logic [31:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input int unsigned c);
        if (c >= 1800 && c <= 2200) return 1;
        if (c >= 18000 && c <= 22000) return 2;
        return 0;
    endfunction

    function automatic bit holds(input int unsigned c, input int id);
`ifdef IR_HYST_EN
        if (id == 1) return (c >= 1700 && c <= 2300);
        if (id == 2) return (c >= 17900 && c <= 22100);
        return 1'b0;
`else
        return cls_of(c) == id;
`endif
    endfunction

    task automatic model_clear();
        m_id = 0; m_run = 0; m_prev = 0; m_miss = 0; m_since = 0; m_chg = 0; m_last = 0;
    endtask

    task automatic model_window(input int unsigned c);
        int k;
        k       = cls_of(c);
        m_chg   = 0;
        m_since = 0;
        m_last  = c;
        if (m_id != 0) begin
            if (holds(c, m_id)) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == DROP) begin
                    m_id = 0; m_chg = 1; m_miss = 0; m_run = 0; m_prev = 0;
                end
            end
        end else begin
            if (k == 0) m_run = 0;
            else if (k == m_prev) m_run++;
            else m_run = 1;
            m_prev = k;
            if (m_run == CONFIRM) begin
                m_id = k; m_chg = 1; m_run = 0; m_prev = 0; m_miss = 0;
            end
        end
    endtask

    task automatic send(input logic [31:0] c);
        @(negedge clk);
        edge_count  = c;
        count_valid = 1'b1;
        @(posedge clk);
        #1;
        count_valid = 1'b0;
        model_window(c);
        check("win_id", beacon_id, m_id);
        check("win_valid", beacon_valid, m_id != 0);
        check("win_changed", beacon_changed, m_chg);
        check("win_last", last_count, m_last);
        check("win_stale", stale, 0);
    endtask

    task automatic idle(input int n);
        bit exp_stale;
        repeat (n) begin
            @(posedge clk);
            #1;
            m_since++;
            m_chg     = 0;
            exp_stale = 0;
            if (m_since == S) begin
                exp_stale = 1;
                m_chg     = (m_id != 0);
                m_id = 0; m_run = 0; m_prev = 0; m_miss = 0;
            end
            check("idle_stale", stale, exp_stale);
            check("idle_id", beacon_id, m_id);
            check("idle_changed", beacon_changed, m_chg);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        count_valid = 1'b0;
        edge_count  = '0;
        repeat (2) @(negedge clk);
        model_clear();
        check("rst_id", beacon_id, 0);
        check("rst_valid", beacon_valid, 0);
        check("rst_changed", beacon_changed, 0);
        check("rst_stale", stale, 0);
        check("rst_last", last_count, 0);
        reset = 1'b0;
    endtask

    initial begin
        int unsigned vals [12];
        int unsigned c;
        vals = '{1800, 2200, 1799, 2201, 18000, 22000, 17999, 22001, 2250, 0, 2000, 20000};

        // Basic lock on A at the third window.
        do_reset();
        send(2000); send(2000); send(2000);
        check("lockA_id", beacon_id, 1);
        idle(2);

        // Lock on B, single miss then recovery, then two misses drop.
        do_reset();
        send(20000); send(20000); send(20000);
        send(500); send(20000); send(500);
        check("miss_reset_id", beacon_id, 2);
        send(500);
        check("drop_id", beacon_id, 0);

        // Candidate switch inside CONFIRM, then abort to SEARCH on a zero window.
        do_reset();
        send(2000); send(20000); send(20000); send(20000);
        check("switch_lockB", beacon_id, 2);
        do_reset();
        send(2000); send(2000); send(0); send(2000);
        check("abort_nolock", beacon_id, 0);

        // Stale timeout while locked, no re-fire, then count_valid on the expiry cycle.
        do_reset();
        send(2000); send(2000); send(2000);
        idle(S + 30);
        send(2000); send(2000); send(2000);
        idle(S - 1);
        send(2000);
        check("expiry_hold", beacon_id, 1);
        idle(3);
        send(500); send(500);
        idle(S + 2);

        // Just outside the A band: miss by default, held with hysteresis; never confirms from SEARCH.
        do_reset();
        send(2000); send(2000); send(2000);
        send(2250); send(2250);
        do_reset();
        send(2250); send(2250); send(2000); send(2000);
        check("hyst_search", beacon_id, 0);
        send(2000);

        // Asynchronous reset mid-CONFIRM clears outputs before any clock edge.
        do_reset();
        send(2000); send(2000);
        #2;
        reset = 1'b1;
        #1;
        check("arst_id", beacon_id, 0);
        check("arst_valid", beacon_valid, 0);
        check("arst_changed", beacon_changed, 0);
        check("arst_stale", stale, 0);
        check("arst_last", last_count, 0);
        @(negedge clk);
        model_clear();
        reset = 1'b0;
        send(2000); send(2000);
        check("arst_nolock", beacon_id, 0);

        // Random windows and short gaps.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    c = vals[$urandom_range(0, 11)];
                2:       c = $urandom_range(1800, 2200);
                3:       c = $urandom_range(18000, 22000);
                4:       c = $urandom;
                default: c = (i % 2 == 0) ? 32'd2000 : 32'd20000;
            endcase
            send(c);
            idle($urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
